// File: rtl/elevator_pkg.sv
// Shared constants and small helpers for the elevator car sequencer.
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;
    localparam int COUNT_W    = 3;   // strictly-above/below counts never exceed 7

    // Car state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] DOOR = 2'd2;

    // One-hot mask selecting a single floor
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] floor);
        floor_bit        = '0;
        floor_bit[floor] = 1'b1;
    endfunction

    // Population count of a floor mask
    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_FLOORS-1:0] mask);
        popcount = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            popcount = popcount + {{(COUNT_W-1){1'b0}}, mask[i]};
        end
    endfunction

endpackage

// File: rtl/elevator_car_sequencer_call_picker.sv
// Combinational call picker: splits pending calls into those above and below
// the car and chooses the direction an idle car should start in.
module call_picker
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic [NUM_FLOORS-1:0] above_o,
    output logic [NUM_FLOORS-1:0] below_o,
    output logic                  dir_up_o
);

    logic [COUNT_W-1:0] above_cnt;
    logic [COUNT_W-1:0] below_cnt;

    // Classify every pending floor relative to the car position
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        above_o = '0;
        below_o = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_o[i] = pending_i[i] && (FLOOR_W'(i) > floor_i);
            below_o[i] = pending_i[i] && (FLOOR_W'(i) < floor_i);
        end
    end

    assign above_cnt = popcount(above_o);
    assign below_cnt = popcount(below_o);

    // Majority side wins, a tie goes up, but never up with nothing above
    assign dir_up_o = (above_cnt >= below_cnt) && (above_o != '0);

endmodule

// File: rtl/elevator_car_sequencer.sv
// Elevator car sequencer: latches floor calls and walks the car through
// IDLE / MOVE / DOOR using one shared down-counter for travel and door dwell.
module elevator_car_sequencer
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req_i,
    output logic [NUM_FLOORS-1:0] floors_pending_o,
    output logic [FLOOR_W-1:0]    current_floor_o,
    output logic                  moving_o,
    output logic                  direction_up_o,
    output logic                  door_open_o,
    output logic                  arrived_o
);

    localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    logic [1:0]            state_q,   state_d;
    logic [TIMER_W-1:0]    timer_q,   timer_d;
    logic [FLOOR_W-1:0]    floor_q,   floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  dir_q,     dir_d;
    logic                  arrived_q, arrived_d;

    // Calls raised this cycle are visible to this cycle's decisions, so an
    // idle car answers a call without waiting for it to be latched first.
    logic [NUM_FLOORS-1:0] pend_eff;
    logic [NUM_FLOORS-1:0] above;
    logic [NUM_FLOORS-1:0] below;
    logic                  pick_up;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  at_limit;
    logic                  calls_beyond;

    assign pend_eff = pending_q | call_req_i;

    call_picker u_call_picker (
        .pending_i (pend_eff),
        .floor_i   (floor_q),
        .above_o   (above),
        .below_o   (below),
        .dir_up_o  (pick_up)
    );

    // The floor the car reaches at the end of the current travel segment;
    // a step off either end of the shaft is refused rather than wrapped.
    assign next_floor = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign at_limit   = dir_q ? (floor_q == FLOOR_W'(NUM_FLOORS - 1)) : (floor_q == '0);

    // Calls further along the travel direction than the floor being reached
    assign calls_beyond = dir_q ? ((above & ~floor_bit(next_floor)) != '0)
                                : ((below & ~floor_bit(next_floor)) != '0);

    // Next-state, timer, floor and call-latch logic
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        arrived_d  = 1'b0;
        clear_mask = '0;

        case (state_q)
            IDLE: begin
                if (pend_eff[floor_q]) begin
                    state_d    = DOOR;
                    timer_d    = DOOR_LOAD;
                    clear_mask = floor_bit(floor_q);
                end else if ((above | below) != '0) begin
                    state_d = MOVE;
                    timer_d = TRAVEL_LOAD;
                    dir_d   = pick_up;
                end
            end

            MOVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (at_limit) begin
                    state_d = IDLE;
                end else begin
                    floor_d   = next_floor;
                    arrived_d = 1'b1;
                    if (pend_eff[next_floor]) begin
                        state_d    = DOOR;
                        timer_d    = DOOR_LOAD;
                        clear_mask = floor_bit(next_floor);
                    end else if (calls_beyond) begin
                        timer_d = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DOOR: begin
                // Calls for the floor the door is open at are absorbed
                clear_mask = floor_bit(floor_q);
                if (call_req_i[floor_q]) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d = pend_eff & ~clear_mask;
    end

    // State registers; reset drops every call and parks the car at floor 0
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            floor_q   <= '0;
            pending_q <= '0;
            dir_q     <= 1'b1;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
            arrived_q <= arrived_d;
        end
    end

    assign floors_pending_o = pending_q;
    assign current_floor_o  = floor_q;
    assign moving_o         = (state_q == MOVE);
    assign door_open_o      = (state_q == DOOR);
    assign direction_up_o   = dir_q;
    assign arrived_o        = arrived_q;

endmodule

// File: tb/tb_elevator_car_sequencer.sv
// Self-checking bench for elevator_car_sequencer: directed scenarios followed by
// random call traffic, all compared against a behavioural car model.
module tb_elevator_car_sequencer;

    localparam int TRAVEL = 4;
    localparam int DWELL  = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] call_req;
    logic [7:0] floors_pending;
    logic [2:0] current_floor;
    logic       moving;
    logic       direction_up;
    logic       door_open;
    logic       arrived;

    elevator_car_sequencer #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DWELL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .call_req_i       (call_req),
        .floors_pending_o (floors_pending),
        .current_floor_o  (current_floor),
        .moving_o         (moving),
        .direction_up_o   (direction_up),
        .door_open_o      (door_open),
        .arrived_o        (arrived)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural car model ----------------
    typedef enum {M_IDLE, M_MOVE, M_DOOR} mode_t;

    mode_t m_mode;
    int    m_floor;
    bit    m_pend[8];
    int    m_left;     // cycles left in the current travel segment or dwell
    bit    m_up;
    bit    m_arr;

    int    tests = 0;
    int    fails = 0;
    int    n_arr;
    int    n_door;
    int    first_door;
    string phase;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_floor = 0;
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_left  = 0;
        m_up    = 1'b1;
        m_arr   = 1'b0;
    endtask

    // Advance the model by one clock edge with the given calls present
    task automatic model_step(input logic [7:0] call);
        bit req[8];
        int na;
        int nb;
        int nf;
        for (int i = 0; i < 8; i++) req[i] = m_pend[i] | call[i];
        m_arr = 1'b0;
        case (m_mode)
            M_IDLE: begin
                na = 0;
                nb = 0;
                for (int i = 0; i < 8; i++) begin
                    if (req[i] && i > m_floor) na++;
                    if (req[i] && i < m_floor) nb++;
                end
                if (req[m_floor]) begin
                    req[m_floor] = 1'b0;
                    m_mode = M_DOOR;
                    m_left = DWELL - 1;
                end else if (na + nb > 0) begin
                    m_mode = M_MOVE;
                    m_left = TRAVEL - 1;
                    m_up   = (na >= nb) && (na > 0);
                end
            end
            M_MOVE: begin
                if (m_left > 0) begin
                    m_left--;
                end else begin
                    nf = m_up ? m_floor + 1 : m_floor - 1;
                    if (nf < 0 || nf > 7) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_floor = nf;
                        m_arr   = 1'b1;
                        if (req[nf]) begin
                            req[nf] = 1'b0;
                            m_mode  = M_DOOR;
                            m_left  = DWELL - 1;
                        end else begin
                            na = 0;
                            for (int i = 0; i < 8; i++)
                                if (req[i] && (m_up ? (i > nf) : (i < nf))) na++;
                            if (na > 0) m_left = TRAVEL - 1;
                            else        m_mode = M_IDLE;
                        end
                    end
                end
            end
            M_DOOR: begin
                req[m_floor] = 1'b0;
                if (call[m_floor])   m_left = DWELL - 1;
                else if (m_left > 0) m_left--;
                else                 m_mode = M_IDLE;
            end
            default: ;
        endcase
        m_pend = req;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] pw;
        for (int i = 0; i < 8; i++) pw[i] = m_pend[i];
        check({phase, ".pending"}, floors_pending, pw);
        check({phase, ".floor"},   current_floor,  m_floor);
        check({phase, ".moving"},  moving,         m_mode == M_MOVE);
        check({phase, ".door"},    door_open,      m_mode == M_DOOR);
        check({phase, ".dir"},     direction_up,   m_up);
        check({phase, ".arrived"}, arrived,        m_arr);
        check({phase, ".excl"},    moving & door_open, 1'b0);
        if (arrived) n_arr++;
        if (door_open) begin
            n_door++;
            if (first_door < 0) first_door = current_floor;
        end
    endtask

    // One clock: check the current cycle, present calls for one edge
    task automatic run_cycle(input logic [7:0] call);
        check_outputs();
        call_req = call;
        model_step(call);
        @(negedge clk);
        call_req = 8'h00;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        call_req = 8'h00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        n_arr      = 0;
        n_door     = 0;
        first_door = -1;
    endtask

    initial begin
        rst_n    = 1'b0;
        call_req = 8'h00;
        clear_obs();
        model_reset();
        @(negedge clk);
        phase = "reset";
        check_outputs();
        rst_n = 1'b1;

        // Call to floor 5 from floor 0: five arrivals, one dwell
        phase = "up5";
        clear_obs();
        run_cycle(8'h20);
        check("up5.moving_rise", moving, 1'b1);
        check("up5.dir_up", direction_up, 1'b1);
        for (int i = 0; i < TRAVEL; i++) run_cycle(8'h00);
        check("up5.first_step_floor", current_floor, 3'd1);
        check("up5.first_step_arrived", arrived, 1'b1);
        for (int i = 0; i < 31; i++) run_cycle(8'h00);
        check("up5.arrivals", n_arr, 5);
        check("up5.door_cycles", n_door, DWELL);
        check("up5.final_floor", current_floor, 3'd5);
        check("up5.final_pending", floors_pending, 8'h00);
        check("up5.final_idle", moving | door_open, 1'b0);

        // Call at the current floor opens the door on the next cycle
        do_reset();
        phase = "here";
        clear_obs();
        run_cycle(8'h01);
        check("here.door_next", door_open, 1'b1);
        for (int i = 0; i < 10; i++) run_cycle(8'h00);
        check("here.door_cycles", n_door, DWELL);
        check("here.no_arrival", n_arr, 0);
        check("here.floor", current_floor, 3'd0);

        // Park at 3, then two calls below and one above: start downwards
        do_reset();
        phase = "split";
        run_cycle(8'h08);
        for (int i = 0; i < 30; i++) run_cycle(8'h00);
        check("split.parked", current_floor, 3'd3);
        clear_obs();
        run_cycle(8'h83);
        check("split.dir_down", direction_up, 1'b0);
        for (int i = 0; i < 120; i++) run_cycle(8'h00);
        check("split.first_served", first_door, 1);
        check("split.drained", floors_pending, 8'h00);

        // Intermediate call on the way up stops the car, then it resumes
        do_reset();
        phase = "stop2";
        run_cycle(8'h40);
        for (int i = 0; i < 50 && m_floor != 1; i++) run_cycle(8'h00);
        clear_obs();
        run_cycle(8'h04);
        for (int i = 0; i < 80; i++) run_cycle(8'h00);
        check("stop2.first_served", first_door, 2);
        check("stop2.final_floor", current_floor, 3'd6);
        check("stop2.door_cycles", n_door, 2 * DWELL);

        // Asynchronous reset in the middle of a run
        do_reset();
        phase = "abort";
        run_cycle(8'h80);
        for (int i = 0; i < 60 && m_floor != 3; i++) run_cycle(8'h00);
        check("abort.pre_moving", moving, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort.floor", current_floor, 3'd0);
        check("abort.moving", moving, 1'b0);
        check("abort.pending", floors_pending, 8'h00);
        check("abort.door", door_open, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(8'h01);
        check("abort.fresh_door", door_open, 1'b1);
        for (int i = 0; i < 10; i++) run_cycle(8'h00);

        // Door re-open during dwell
        do_reset();
        phase = "reopen";
        run_cycle(8'h10);
        for (int i = 0; i < 40 && m_mode != M_DOOR; i++) run_cycle(8'h00);
        run_cycle(8'h00);
        run_cycle(8'h00);
        run_cycle(8'h10);
        clear_obs();
        for (int i = 0; i < 10; i++) run_cycle(8'h00);
        check("reopen.further_cycles", n_door, DWELL);
        check("reopen.floor", current_floor, 3'd4);

        // Random traffic with occasional resets
        do_reset();
        phase = "rand";
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] call;
            int         pick;
            pick = $urandom_range(0, 99);
            if (pick < 8)       call = 8'($urandom_range(0, 255));
            else if (pick < 20) call = 8'(1 << $urandom_range(0, 7));
            else                call = 8'h00;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                run_cycle(call);
            end
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
